mod_mult_seq: RTL and testbench

- Sequential modular multiplier for the RSA datapath. Computes (a * b) mod n on WIDTH-bit operands.
- Sits directly downstream of the 6-bit operand-select mux in the modular exponentiation loop.
  - The mux output (running result or base) drives operand a.
- Uses an interleaved shift/add/reduce algorithm, MSB-first on b, one bit per clock.
- Start/done handshake toward the exponentiation controller.

---
 rtl/mod_mult_seq.sv | 146 ++++++++++++++
 tb/tb_mod_mult_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_mult_seq.sv
// Sequential modular multiplier: result = (a * b) mod n.
// Interleaved shift/add/reduce, scanning b MSB-first at one bit per clock.
// Operands are latched when a start is accepted; the live inputs may change afterwards.
// Invalid operands (n == 0, a >= n, b >= n) finish at once with err=1 and result=0.
module mod_mult_seq #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_invalid;
    logic [WIDTH:0]   w_dbl;
    logic [WIDTH:0]   w_red1;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_red2;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_acc;
    logic [IW-1:0]    r_idx;
    logic             r_err_pend;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_busy;
    logic             r_err;

    // Operand check on the live inputs, evaluated only when a start is accepted.
    assign w_invalid = (n == '0) || (a >= n) || (b >= n);

    // One interleaved step; WIDTH+1 bits suffice because acc < n and a < n.
    always_comb begin
        w_dbl  = {r_acc, 1'b0};
        w_red1 = (w_dbl >= {1'b0, r_n}) ? (w_dbl - {1'b0, r_n}) : w_dbl;
        w_add  = r_b[r_idx] ? (w_red1 + {1'b0, r_a}) : w_red1;
        w_red2 = (w_add >= {1'b0, r_n}) ? (w_add - {1'b0, r_n}) : w_add;
    end

    // Next-state decode: start only matters in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_invalid ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == '0) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_n        <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_err_pend <= 1'b0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_n        <= n;
                        r_acc      <= '0;
                        r_idx      <= IW'(WIDTH - 1);
                        r_err      <= 1'b0;
                        r_err_pend <= w_invalid;
                        r_busy     <= ~w_invalid;
                    end
                end
                S_RUN: begin
                    r_acc <= w_red2[WIDTH-1:0];
                    if (r_idx == '0) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_FIN: begin
                    r_result <= r_err_pend ? '0 : r_acc;
                    r_err    <= r_err_pend;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = r_busy;
    assign err    = r_err;

endmodule

// File: tb/tb_mod_mult_seq.sv
// Self-checking bench for mod_mult_seq; expected results come from (a*b)%n integer arithmetic.
module tb_mod_mult_seq;

    localparam int WIDTH = 6;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             err;

    int checks = 0;
    int errors = 0;

    mod_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .n      (n),
        .result (result),
        .done   (done),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_bad(input int ia, input int ib, input int in_);
        return (in_ == 0) || (ia >= in_) || (ib >= in_);
    endfunction

    function automatic int ref_mod(input int ia, input int ib, input int in_);
        if (is_bad(ia, ib, in_)) return 0;
        return (ia * ib) % in_;
    endfunction

    // Drive one start, then wait (bounded) for done. lat counts edges after the accepting edge.
    task automatic do_op(input int ia, input int ib, input int in_, input bit hold,
                         output int lat, output int bcnt, output int res,
                         output logic e, output logic bd);
        lat  = -1;
        bcnt = 0;
        res  = -1;
        e    = 1'bx;
        bd   = 1'bx;
        @(negedge clk);
        a = WIDTH'(ia); b = WIDTH'(ib); n = WIDTH'(in_); start = 1'b1;
        @(posedge clk); #1;
        if (busy) bcnt++;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (hold) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom); n = WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                lat = k; res = int'(result); e = err; bd = busy;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; n = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || result !== '0) begin
                errors++;
                $display("FAIL idle_hold cycle %0d got done=%b busy=%b err=%b result=%0d want all 0",
                         k, done, busy, err, result);
            end
        end
    endtask

    task automatic test_basic;
        int lat, bcnt, res;
        logic e, bd;
        do_op(5, 7, 11, 1'b0, lat, bcnt, res, e, bd);
        checks++; if (lat != WIDTH + 1) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, WIDTH + 1); end
        checks++; if (bcnt != WIDTH) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", bcnt, WIDTH); end
        checks++; if (res != 2) begin errors++; $display("FAIL basic_result got %0d want 2", res); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", e); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got %b want 0", bd); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
        checks++; if (result !== 6'd2) begin errors++; $display("FAIL basic_result_hold got %0d want 2", result); end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt, res;
        logic e, bd;
        do_op(60, 60, 61, 1'b0, lat, bcnt, res, e, bd);
        checks++; if (res != 1) begin errors++; $display("FAIL b2b_first_result got %0d want 1", res); end
        checks++; if (lat != WIDTH + 1) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", lat, WIDTH + 1); end
        do_op(2, 3, 7, 1'b0, lat, bcnt, res, e, bd);
        checks++; if (res != 6) begin errors++; $display("FAIL b2b_second_result got %0d want 6", res); end
        checks++; if (lat != WIDTH + 1) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", lat, WIDTH + 1); end
    endtask

    task automatic test_invalid;
        int lat, bcnt, res;
        logic e, bd;
        do_op(3, 2, 0, 1'b0, lat, bcnt, res, e, bd);
        checks++; if (lat != 1) begin errors++; $display("FAIL inv_n0_latency got %0d want 1", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL inv_n0_err got %b want 1", e); end
        checks++; if (res != 0) begin errors++; $display("FAIL inv_n0_result got %0d want 0", res); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL inv_err_hold got %b want 1", err); end
        do_op(12, 3, 11, 1'b0, lat, bcnt, res, e, bd);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL inv_a_ge_n_err got %b want 1", e); end
        checks++; if (res != 0) begin errors++; $display("FAIL inv_a_ge_n_result got %0d want 0", res); end
        do_op(4, 5, 11, 1'b0, lat, bcnt, res, e, bd);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL inv_clear_err got %b want 0", e); end
        checks++; if (res != 9) begin errors++; $display("FAIL inv_clear_result got %0d want 9", res); end
    endtask

    task automatic test_start_ignored;
        int lat, bcnt, res, extra;
        logic e, bd;
        do_op(5, 7, 11, 1'b1, lat, bcnt, res, e, bd);
        start = 1'b0;
        checks++; if (res != 2) begin errors++; $display("FAIL ign_result got %0d want 2", res); end
        checks++; if (lat != WIDTH + 1) begin errors++; $display("FAIL ign_latency got %0d want %0d", lat, WIDTH + 1); end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL ign_extra_done got %0d want 0", extra); end
    endtask

    task automatic test_reset_mid;
        int lat, bcnt, res, dcnt;
        logic e, bd;
        @(negedge clk);
        a = 6'd9; b = 6'd10; n = 6'd13; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (result !== '0) begin errors++; $display("FAIL rstmid_result got %0d want 0", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rstmid_done_err got %b%b want 00", done, err); end
        @(negedge clk); rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", dcnt); end
        checks++; if (result !== '0) begin errors++; $display("FAIL rstmid_result_after got %0d want 0", result); end
        do_op(3, 4, 13, 1'b0, lat, bcnt, res, e, bd);
        checks++; if (res != 12) begin errors++; $display("FAIL rstmid_next_result got %0d want 12", res); end
    endtask

    task automatic test_random;
        int lat, bcnt, res, ia, ib, in_, exp_res, exp_lat;
        logic e, bd;
        bit bad;
        for (int it = 0; it < 30; it++) begin
            in_ = $urandom_range(63, 1);
            if ($urandom_range(4, 0) == 0) begin
                ia = $urandom_range(63, 0);
                ib = $urandom_range(63, 0);
            end else begin
                ia = $urandom_range(in_ - 1, 0);
                ib = $urandom_range(in_ - 1, 0);
            end
            bad     = is_bad(ia, ib, in_);
            exp_res = ref_mod(ia, ib, in_);
            exp_lat = bad ? 1 : WIDTH + 1;
            do_op(ia, ib, in_, 1'b0, lat, bcnt, res, e, bd);
            checks++;
            if (res != exp_res || e !== logic'(bad) || lat != exp_lat) begin
                errors++;
                $display("FAIL rand a=%0d b=%0d n=%0d got res=%0d err=%b lat=%0d want res=%0d err=%0d lat=%0d",
                         ia, ib, in_, res, e, lat, exp_res, bad, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_invalid();
        test_start_ignored();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
